// File: rtl/lsu_dmem.sv
// lsu_dmem: data-memory responder behind the LSU load/store interface.
// Accepts one store and one load per cycle. A store commits its addressed byte lanes at the
// clock edge. A load returns right-aligned, extended data one cycle after it is issued.
// After reset the array can be zeroed by a clear sequence. Misaligned or out-of-range
// accesses are reported with a one-cycle error pulse.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   stall        freezes captured load data (stores still commit)
//   wr_addr      store byte address
//   wr_data      store data, right-aligned
//   wr_en        store request
//   wr_size      00 byte, 01 half, 10 word, 11 reserved
//   rd_addr      load byte address
//   rd_en        load request
//   rd_size      same encoding as wr_size
//   rd_zero_ext  1 zero-extends a sub-word load, 0 sign-extends it
//   rd_data      load result, valid the cycle after issue
//   mem_busy     high while the clear sequence runs
//   access_err   pulses for a faulting access issued the previous cycle
//   err_addr     byte address of the most recent faulting access
module lsu_dmem #(
    parameter int unsigned ADDR_W         = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic [1:0]  wr_size,
    input  logic [31:0] rd_addr,
    input  logic        rd_en,
    input  logic [1:0]  rd_size,
    input  logic        rd_zero_ext,
    output logic [31:0] rd_data,
    output logic        mem_busy,
    output logic        access_err,
    output logic [31:0] err_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic                mem_busy_q;
    logic [31:0]         rd_data_q;
    logic                access_err_q;
    logic [31:0]         err_addr_q;

    logic [31:0]         mem_q [DEPTH];

    // An access faults when it is out of range or not naturally aligned for its size.
    function automatic logic addr_fault(input logic [31:0] addr, input logic [1:0] size);
        logic oor;
        logic mis;
        oor = |addr[31:ADDR_W+2];
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr[0];
            2'b10:   mis = |addr[1:0];
            default: mis = 1'b1;
        endcase
        return oor | mis;
    endfunction

    logic              ready;
    logic              wr_fault;
    logic              rd_fault;
    logic              wr_flt;
    logic              rd_flt;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;

    assign ready    = (state_q == StReady);
    assign wr_fault = addr_fault(wr_addr, wr_size);
    assign rd_fault = addr_fault(rd_addr, rd_size);
    assign wr_flt   = ready & wr_en & wr_fault;
    assign rd_flt   = ready & rd_en & rd_fault;
    assign wr_idx   = wr_addr[ADDR_W+1:2];
    assign rd_idx   = rd_addr[ADDR_W+1:2];

    // Single write port, shared between the clear sequence and legal stores.
    logic              mem_we;
    logic [ADDR_W-1:0] mem_widx;
    logic [3:0]        mem_wbe;
    logic [31:0]       mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = wr_idx;
        mem_wbe   = 4'b0000;
        mem_wdata = 32'h0;
        if (!rst) begin
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_widx  = clr_idx_q;
                mem_wbe   = 4'b1111;
            end else if (wr_en && !wr_fault) begin
                mem_we = 1'b1;
                // Data is replicated across lanes so the byte enables pick the right copy.
                case (wr_size)
                    2'b00: begin
                        mem_wbe   = 4'b0001 << wr_addr[1:0];
                        mem_wdata = {4{wr_data[7:0]}};
                    end
                    2'b01: begin
                        mem_wbe   = 4'b0011 << {wr_addr[1], 1'b0};
                        mem_wdata = {2{wr_data[15:0]}};
                    end
                    default: begin
                        mem_wbe   = 4'b1111;
                        mem_wdata = wr_data;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wbe[k]) begin
                    mem_q[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Read path sees pre-store contents, giving read-before-write on same-word collisions.
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;

    always_comb begin
        rd_word  = mem_q[rd_idx];
        rd_shift = rd_word >> {rd_addr[1:0], 3'b000};
        case (rd_size)
            2'b00:   rd_ext = rd_zero_ext ? {24'h0, rd_shift[7:0]}
                                          : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = rd_zero_ext ? {16'h0, rd_shift[15:0]}
                                          : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q    <= 32'h0;
            access_err_q <= 1'b0;
            err_addr_q   <= 32'h0;
            clr_idx_q    <= '0;
            if (CLEAR_ON_RESET) begin
                state_q    <= StClear;
                mem_busy_q <= 1'b1;
            end else begin
                state_q    <= StReady;
                mem_busy_q <= 1'b0;
            end
        end else begin
            access_err_q <= wr_flt | rd_flt;
            // Store address takes priority when both requests fault.
            if (wr_flt) begin
                err_addr_q <= wr_addr;
            end else if (rd_flt) begin
                err_addr_q <= rd_addr;
            end
            case (state_q)
                StClear: begin
                    clr_idx_q <= clr_idx_q + ADDR_W'(1);
                    if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_q    <= StReady;
                        mem_busy_q <= 1'b0;
                    end
                end
                default: begin
                    if (rd_en && !stall) begin
                        rd_data_q <= rd_fault ? 32'h0 : rd_ext;
                    end
                end
            endcase
        end
    end

    assign rd_data    = rd_data_q;
    assign mem_busy   = mem_busy_q;
    assign access_err = access_err_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem with a 16-word array and clear-on-reset enabled.
module tb_lsu_dmem;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [1:0]  wr_size;
    logic [31:0] rd_addr;
    logic        rd_en;
    logic [1:0]  rd_size;
    logic        rd_zero_ext;
    logic [31:0] rd_data;
    logic        mem_busy;
    logic        access_err;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] SzB = 2'b00;
    localparam logic [1:0] SzH = 2'b01;
    localparam logic [1:0] SzW = 2'b10;

    lsu_dmem #(
        .ADDR_W         (4),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_size     (wr_size),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_size     (rd_size),
        .rd_zero_ext (rd_zero_ext),
        .rd_data     (rd_data),
        .mem_busy    (mem_busy),
        .access_err  (access_err),
        .err_addr    (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled at the same point.
    task automatic do_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_size = s;
        do_cycle();
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s, input logic z);
        rd_en = 1'b1; rd_addr = a; rd_size = s; rd_zero_ext = z;
        do_cycle();
        rd_en = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int err_seen;

        rst = 1'b1; stall = 1'b0;
        wr_addr = '0; wr_data = '0; wr_en = 1'b0; wr_size = SzW;
        rd_addr = '0; rd_en = 1'b0; rd_size = SzW; rd_zero_ext = 1'b0;
        do_cycle();
        do_cycle();
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_access_err", 32'(access_err), 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_busy", 32'(mem_busy), 32'h1);

        // Clear phase: faulting store and legal load are both ignored.
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'h1; wr_size = SzW;
        rd_en = 1'b1; rd_addr = 32'h3C; rd_size = SzW;
        busy_cnt = 1;
        err_seen = 0;
        for (int i = 0; i < 40; i++) begin
            do_cycle();
            if (access_err) err_seen++;
            if (!mem_busy) break;
            busy_cnt++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'd16);
        check("clear_no_err", 32'(err_seen), 32'h0);
        check("clear_rd_data", rd_data, 32'h0);

        load(32'h3C, SzW, 1'b0);
        check("cleared_3c", rd_data, 32'h0);

        // Sub-word extraction and extension.
        store(32'h10, 32'hDEADBEEF, SzW);
        load(32'h13, SzB, 1'b1);
        check("lbu_13", rd_data, 32'h000000DE);
        load(32'h13, SzB, 1'b0);
        check("lb_13", rd_data, 32'hFFFFFFDE);
        load(32'h12, SzH, 1'b0);
        check("lh_12", rd_data, 32'hFFFFDEAD);
        load(32'h10, SzH, 1'b1);
        check("lhu_10", rd_data, 32'h0000BEEF);
        load(32'h10, SzB, 1'b0);
        check("lb_10", rd_data, 32'hFFFFFFEF);
        load(32'h10, SzW, 1'b1);
        check("lw_10", rd_data, 32'hDEADBEEF);

        // Lane-masked stores; upper store data bits must be ignored.
        store(32'h11, 32'hFFFFFF5A, SzB);
        load(32'h10, SzW, 1'b0);
        check("sb_11", rd_data, 32'hDEAD5AEF);
        store(32'h12, 32'hABCD1234, SzH);
        load(32'h10, SzW, 1'b0);
        check("sh_12", rd_data, 32'h12345AEF);

        // Misaligned load.
        load(32'h12, SzW, 1'b0);
        check("mis_ld_err", 32'(access_err), 32'h1);
        check("mis_ld_addr", err_addr, 32'h12);
        check("mis_ld_data", rd_data, 32'h0);
        do_cycle();
        check("err_pulse_end", 32'(access_err), 32'h0);
        check("err_addr_hold", err_addr, 32'h12);

        // Misaligned half store is dropped.
        store(32'h15, 32'hFFFF, SzH);
        check("mis_st_err", 32'(access_err), 32'h1);
        check("mis_st_addr", err_addr, 32'h15);
        load(32'h14, SzW, 1'b0);
        check("mis_st_dropped", rd_data, 32'h0);
        check("good_ld_no_err", 32'(access_err), 32'h0);

        // Out-of-range store would alias word 0 if the range check were missing.
        store(32'h40, 32'h55, SzW);
        check("oor_err", 32'(access_err), 32'h1);
        check("oor_addr", err_addr, 32'h40);
        load(32'h00, SzW, 1'b0);
        check("oor_dropped", rd_data, 32'h0);

        // Both requests fault: store address wins. Reserved size also faults.
        wr_en = 1'b1; wr_addr = 32'h80; wr_data = 32'h9; wr_size = SzW;
        rd_en = 1'b1; rd_addr = 32'h3; rd_size = SzW;
        do_cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        check("both_err", 32'(access_err), 32'h1);
        check("both_addr", err_addr, 32'h80);
        load(32'h04, 2'b11, 1'b0);
        check("rsvd_err", 32'(access_err), 32'h1);
        check("rsvd_addr", err_addr, 32'h04);

        // Stall holds load data but still reports errors.
        store(32'h14, 32'hCAFEF00D, SzW);
        load(32'h10, SzW, 1'b0);
        check("pre_stall", rd_data, 32'h12345AEF);
        stall = 1'b1;
        load(32'h14, SzW, 1'b0);
        check("stall_hold", rd_data, 32'h12345AEF);
        load(32'h16, SzW, 1'b0);
        check("stall_err", 32'(access_err), 32'h1);
        check("stall_err_data", rd_data, 32'h12345AEF);
        store(32'h18, 32'h0BADC0DE, SzW);
        stall = 1'b0;
        do_cycle();
        check("idle_hold", rd_data, 32'h12345AEF);
        load(32'h14, SzW, 1'b0);
        check("unstall_ld", rd_data, 32'hCAFEF00D);
        load(32'h18, SzW, 1'b0);
        check("stall_store", rd_data, 32'h0BADC0DE);

        // Same-word store and load in one cycle: read-before-write.
        store(32'h20 & 32'h3C, 32'h7, SzW);
        wr_en = 1'b1; wr_addr = 32'h20 & 32'h3C; wr_data = 32'h1; wr_size = SzW;
        rd_en = 1'b1; rd_addr = 32'h20 & 32'h3C; rd_size = SzW;
        do_cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rbw_old", rd_data, 32'h7);
        load(32'h20 & 32'h3C, SzW, 1'b0);
        check("rbw_new", rd_data, 32'h1);

        // Reset mid-operation restarts the clear sequence.
        load(32'h12, SzW, 1'b0);
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
        check("rerst_rd_data", rd_data, 32'h0);
        check("rerst_err_addr", err_addr, 32'h0);
        check("rerst_busy", 32'(mem_busy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Data-memory responder on the far side of the LSU load/store interface.
- Accepts at most one store and/or load request per cycle from the LSU execute stage.
- Commits stores with byte-lane masking and returns load data registered, one cycle later, in time for the LSU writeback stage.
- Clears its array after reset, detects misaligned or out-of-range accesses, and holds load data across pipeline stalls.

Parameters:
- ADDR_W, 10, word-index width; DEPTH = 2**ADDR_W 32-bit words (4 KiB default).
- CLEAR_ON_RESET, 1, when 1 the array is zeroed by a clear sequence after reset; when 0 the block is ready immediately and contents are undefined.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes captured load data.
- wr_addr  in  32  store byte address.
- wr_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- wr_en  in  1  store request.
- wr_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- rd_addr  in  32  load byte address.
- rd_en  in  1  load request.
- rd_size  in  2  same encoding as wr_size.
- rd_zero_ext  in  1  1 zero-extends, 0 sign-extends a sub-word load.
- rd_data  out  32  load result, right-aligned and extended, valid the cycle after issue.
- mem_busy  out  1  high while the clear sequence runs.
- access_err  out  1  one-cycle pulse, registered, for a faulting access issued the previous cycle.
- err_addr  out  32  byte address of the most recent faulting access.

Behaviour:
- Reset (rst=1 at an edge):
  - rd_data=0, access_err=0, err_addr=0.
  - State goes to CLEAR with clear index 0 and mem_busy=1 if CLEAR_ON_RESET=1; otherwise state goes to READY with mem_busy=0.
  - Reset asserted mid-clear or mid-operation restarts from this point.
- FSM states:
  - CLEAR: writes 0 to word[idx] each cycle and increments idx. Leaves for READY after writing word DEPTH-1, i.e. DEPTH cycles after reset release.
  - READY: services requests.
  - There is no other transition.
- In CLEAR, all requests are ignored (no write, no error), rd_data is held at 0, and mem_busy=1.
- Address decode:
  - Word index = addr[ADDR_W+1:2]; byte offset = addr[1:0].
  - Out of range: any of addr[31:ADDR_W+2] nonzero.
  - Misaligned: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
- Faulting store: dropped, memory unchanged.
- Faulting load: rd_data=0 next cycle, unless stalled.
- access_err and err_addr:
  - access_err=1 on the next cycle when either request faults.
  - err_addr takes the faulting address; if both requests fault, wr_addr wins.
  - err_addr holds until the next fault or reset.
- Store (READY, wr_en=1, legal): writes only the addressed lanes at the edge, little-endian. Byte k occupies bits [8k+7:8k].
  - Byte: lane = offset, from wr_data[7:0].
  - Half: lanes offset and offset+1, from wr_data[15:0].
  - Word: all lanes.
- Stores commit regardless of stall. A repeated store while stalled is idempotent.
- Load (READY, rd_en=1, legal, stall=0): at the edge, rd_data = selected lanes shifted to bit 0, then zero- or sign-extended per rd_size/rd_zero_ext.
- Word loads ignore rd_zero_ext.
- Load latency is exactly 1 cycle.
- If rd_en=0 and stall=0, rd_data holds its last value.
- If stall=1, rd_data holds (load not captured) but access_err is still reported.
- Simultaneous wr_en and rd_en to the same word: read-before-write; rd_data reflects pre-store contents, and the store commits.
- Array: single write port, single synchronous read port; inferable as block RAM.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_W=4: pulse rst -> mem_busy=1 for exactly 16 cycles, then 0. A load of 0x3C issued during CLEAR -> rd_data=0 with no error. After clear, load 0x3C -> rd_data=0x00000000.
- Store word 0xDEADBEEF @0x10, then load byte @0x13 with zero_ext=1 -> 0x000000DE. Load byte @0x13 with zero_ext=0 -> 0xFFFFFFDE. Load half @0x12 with zero_ext=0 -> 0xFFFFDEAD.
- Store byte 0x5A @0x11 over 0xDEADBEEF -> word load @0x10 returns 0xDEAD5AEF. Store half 0x1234 @0x12 -> 0x12345AEF.
- Misaligned load word @0x12 -> next cycle access_err=1 for one cycle, err_addr=0x12, rd_data=0. Store half @0x15 -> memory unchanged and access_err pulses.
- Out of range with ADDR_W=4: store @0x40 -> dropped, access_err=1, err_addr=0x40.
- Stall: load @0x10 returns X. Assert stall and issue a load @0x14 -> rd_data stays X. Release stall and reissue -> value @0x14 returns one cycle later. Same-cycle store 0x1 and load @0x20 holding 0x7 -> rd_data=0x7, and a subsequent load returns 0x1.
